// File: rtl/hamming74_encoder_stream.sv
// Streaming Hamming(7,4) encoder with a small output FIFO.
// Optional single-bit error injection on the stored codeword.
module hamming74_encoder_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_data,
    input  logic                       inj_en,
    input  logic [2:0]                 inj_pos,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [6:0]                 out_code,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNT_W-1:0]           word_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [6:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic [6:0] code;
    logic [6:0] flip;
    logic [6:0] wdata;

    // Parity layout matches the partner decoder's syndrome equations.
    always_comb begin
        code[3:0] = in_data;
        code[4]   = in_data[0] ^ in_data[1] ^ in_data[3];
        code[5]   = in_data[0] ^ in_data[2] ^ in_data[3];
        code[6]   = in_data[1] ^ in_data[2] ^ in_data[3];
    end

    always_comb begin
        flip = '0;
        if (inj_en && inj_pos != 3'd7) begin
            flip = 7'(1) << inj_pos;
        end
        wdata = code ^ flip;
    end

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign push  = in_valid && !full;
    assign pop   = !empty && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is left uncleared; the empty gate on out_code hides stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_code  = empty ? 7'h00 : mem_q[rd_ptr_q];
    assign level     = level_q;
    assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_hamming74_encoder_stream.sv
// Directed and table-driven bench for hamming74_encoder_stream.
// Expected codewords are hand-computed constants plus a parity model.
module tb_hamming74_encoder_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       inj_en;
    logic [2:0] inj_pos;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_code;
    logic [2:0] level;
    logic [15:0] word_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int acc    = 0;

    always #5 clk = ~clk;

    hamming74_encoder_stream #(.DEPTH(4), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .inj_en   (inj_en),
        .inj_pos  (inj_pos),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_code (out_code),
        .level    (level),
        .word_cnt (word_cnt)
    );

    typedef struct {
        logic [3:0] d;
        logic       en;
        logic [2:0] pos;
        logic [6:0] exp;
    } vec_t;

    vec_t vt [21];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] c;
        c[3:0] = d;
        c[4] = d[0] ^ d[1] ^ d[3];
        c[5] = d[0] ^ d[2] ^ d[3];
        c[6] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    function automatic logic [2:0] syn(input logic [6:0] c);
        logic [2:0] s;
        s[0] = c[4] ^ c[0] ^ c[1] ^ c[3];
        s[1] = c[5] ^ c[0] ^ c[2] ^ c[3];
        s[2] = c[6] ^ c[1] ^ c[2] ^ c[3];
        return s;
    endfunction

    initial begin
        logic [6:0] tbl [16];
        logic [6:0] q[$];
        logic [6:0] held;
        logic [6:0] exp_c;
        logic       stall;
        tbl = '{7'h00, 7'h31, 7'h52, 7'h63, 7'h64, 7'h55, 7'h36, 7'h07,
                7'h78, 7'h49, 7'h2A, 7'h1B, 7'h1C, 7'h2D, 7'h4E, 7'h7F};
        for (int i = 0; i < 16; i++)
            vt[i] = '{d: 4'(i), en: 1'b0, pos: 3'd0, exp: tbl[i]};
        vt[16] = '{d: 4'h0, en: 1'b1, pos: 3'd2, exp: 7'h04};
        vt[17] = '{d: 4'hB, en: 1'b1, pos: 3'd6, exp: 7'h5B};
        vt[18] = '{d: 4'hB, en: 1'b1, pos: 3'd7, exp: 7'h1B};
        vt[19] = '{d: 4'h5, en: 1'b0, pos: 3'd3, exp: 7'h55};
        vt[20] = '{d: 4'h3, en: 1'b1, pos: 3'd0, exp: 7'h62};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 4'h0;
        inj_en = 1'b0;
        inj_pos = 3'd7;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_word_cnt", word_cnt, 0);
        chk("rst_out_code", out_code, 0);
        rst_n = 1'b1;

        in_data = 'x;
        step();
        step();
        chk("xdata_out_valid", out_valid, 0);
        chk("xdata_out_code", out_code, 0);
        chk("xdata_word_cnt", word_cnt, 0);

        // encode table streamed back to back with out_ready high
        for (int i = 0; i < 21; i++) begin
            in_valid = 1'b1;
            in_data = vt[i].d;
            inj_en = vt[i].en;
            inj_pos = vt[i].pos;
            step();
            acc++;
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_code", i), out_code, vt[i].exp);
            chk($sformatf("vec%0d_level", i), level, 1);
            if (i < 16)
                chk($sformatf("vec%0d_syn", i), syn(out_code), 0);
        end
        in_valid = 1'b0;
        inj_en = 1'b0;
        step();
        chk("tbl_drain_level", level, 0);
        chk("tbl_word_cnt", word_cnt, acc);

        // injection request without a valid word must not leak
        inj_en = 1'b1;
        inj_pos = 3'd0;
        step();
        chk("idle_inj_level", level, 0);
        inj_en = 1'b0;
        in_valid = 1'b1;
        in_data = 4'hB;
        step();
        acc++;
        in_valid = 1'b0;
        chk("idle_inj_code", out_code, 7'h1B);
        step();

        // backpressure: fill, hold off a fifth word, drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data = 4'(i);
            step();
            acc++;
        end
        chk("bp_level_full", level, 4);
        chk("bp_in_ready", in_ready, 0);
        in_data = 4'h5;
        step();
        step();
        chk("bp_hold_level", level, 4);
        chk("bp_hold_cnt", word_cnt, acc);
        chk("bp_stall_code", out_code, 7'h31);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("bp_out%0d", i), out_code, tbl[i]);
            step();
        end
        chk("bp_empty", out_valid, 0);

        // simultaneous push and pop at level 2
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h7;
        step();
        in_data = 4'h8;
        step();
        acc += 2;
        chk("sim_level_pre", level, 2);
        out_ready = 1'b1;
        in_data = 4'h9;
        step();
        acc++;
        chk("sim_level_a", level, 2);
        chk("sim_head_a", out_code, 7'h78);
        in_data = 4'hA;
        step();
        acc++;
        chk("sim_level_b", level, 2);
        chk("sim_head_b", out_code, 7'h49);
        in_valid = 1'b0;
        step();
        chk("sim_head_c", out_code, 7'h2A);
        step();
        chk("sim_level_end", level, 0);
        chk("sim_word_cnt", word_cnt, acc);

        // random traffic against a queue scoreboard
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data = 4'($urandom);
            inj_en = 1'($urandom_range(0, 1));
            inj_pos = 3'($urandom);
            #3;
            chk("rnd_level", level, q.size());
            chk("rnd_in_ready", in_ready, q.size() < 4);
            chk("rnd_out_valid", out_valid, q.size() != 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_pop_empty", 1, 0);
                end else begin
                    exp_c = q.pop_front();
                    chk("rnd_code", out_code, exp_c);
                end
            end
            stall = out_valid && !out_ready;
            held = out_code;
            if (in_valid && in_ready) begin
                exp_c = enc(in_data);
                if (inj_en && inj_pos != 3'd7)
                    exp_c[inj_pos] = ~exp_c[inj_pos];
                q.push_back(exp_c);
                acc++;
            end
            step();
            if (stall)
                chk("rnd_stall_code", out_code, held);
        end
        in_valid = 1'b0;
        inj_en = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (q.size() != 0) begin
                exp_c = q.pop_front();
                chk("rnd_drain_code", out_code, exp_c);
            end
            step();
        end
        chk("rnd_drain_level", level, 0);
        chk("rnd_word_cnt", word_cnt, acc & 16'hFFFF);

        // run the counter up to its wrap point
        in_valid = 1'b1;
        in_data = 4'h0;
        while ((acc & 16'hFFFF) != 16'hFFFF) begin
            step();
            acc++;
        end
        in_valid = 1'b0;
        step();
        chk("cnt_max", word_cnt, 16'hFFFF);
        in_valid = 1'b1;
        step();
        acc++;
        in_valid = 1'b0;
        chk("cnt_wrap", word_cnt, 0);
        step();

        // asynchronous reset in the middle of buffered traffic
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 4'h6;
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_level", level, 0);
        chk("arst_word_cnt", word_cnt, 0);
        chk("arst_out_code", out_code, 0);
        #3;
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data = 4'hF;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_code", out_code, 7'h7F);
        chk("post_rst_level", level, 1);
        chk("post_rst_cnt", word_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
